// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, lane counts and controller state type for the SDF butterfly
// Contents: default DIN_WIDTH/WIDTH/DEPTH/BLK, select width, bfly_state_e (FILL, BFLY, EMIT).
package fft_pkg;

    localparam int DIN_WIDTH = 10;
    localparam int WIDTH     = 11;
    localparam int DEPTH     = 16;
    localparam int BLK       = 16;
    localparam int SEL_W     = 3;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        BFLY = 2'd1,
        EMIT = 2'd2
    } bfly_state_e;

endpackage

// File: rtl/bfly_add_sub.sv
// rtl/bfly_add_sub.sv - combinational per-lane sign extension, sum and difference
// Ports:
//   a     in  DEPTH x WIDTH      delayed operand (already WIDTH bits)
//   b     in  DEPTH x DIN_WIDTH  fresh input operand, two's complement
//   b_ext out DEPTH x WIDTH      b sign-extended
//   sum   out DEPTH x WIDTH      a + b_ext
//   diff  out DEPTH x WIDTH      a - b_ext
module bfly_add_sub
    import fft_pkg::*;
#(
    parameter int DIN_WIDTH = fft_pkg::DIN_WIDTH,
    parameter int WIDTH     = fft_pkg::WIDTH,
    parameter int DEPTH     = fft_pkg::DEPTH
) (
    input  logic [DEPTH-1:0][WIDTH-1:0]     a,
    input  logic [DEPTH-1:0][DIN_WIDTH-1:0] b,
    output logic [DEPTH-1:0][WIDTH-1:0]     b_ext,
    output logic [DEPTH-1:0][WIDTH-1:0]     sum,
    output logic [DEPTH-1:0][WIDTH-1:0]     diff
);

    // One guard bit over the input width keeps a+b and a-b exact, so plain
    // modular WIDTH-bit arithmetic is sufficient (no saturation).
    for (genvar i = 0; i < DEPTH; i++) begin : g_lane
        assign b_ext[i] = {{(WIDTH-DIN_WIDTH){b[i][DIN_WIDTH-1]}}, b[i]};
        assign sum[i]   = a[i] + b_ext[i];
        assign diff[i]  = a[i] - b_ext[i];
    end

endmodule

// File: rtl/bfly_sdf_16.sv
// rtl/bfly_sdf_16.sv - radix-2 single-path delay-feedback butterfly, 16 lanes, 16-beat distance
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   din_valid           beat strobe; nothing advances without it
//   din_R, din_Q        DEPTH x DIN_WIDTH signed input lanes
//   dout_valid          dout_R/dout_Q/select carry a result
//   dout_R, dout_Q      DEPTH x WIDTH signed butterfly result lanes
//   select              twiddle index for the downstream multiplier
// Option: BFLY_DOUT_REG_EN adds one more output register stage (latency 2).
module bfly_sdf_16
    import fft_pkg::*;
#(
    parameter int DIN_WIDTH = fft_pkg::DIN_WIDTH,
    parameter int WIDTH     = fft_pkg::WIDTH,
    parameter int DEPTH     = fft_pkg::DEPTH,
    parameter int BLK       = fft_pkg::BLK
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            din_valid,
    input  logic [DEPTH-1:0][DIN_WIDTH-1:0] din_R,
    input  logic [DEPTH-1:0][DIN_WIDTH-1:0] din_Q,
    output logic                            dout_valid,
    output logic [DEPTH-1:0][WIDTH-1:0]     dout_R,
    output logic [DEPTH-1:0][WIDTH-1:0]     dout_Q,
    output logic [SEL_W-1:0]                select
);

    localparam int CNT_W = $clog2(BLK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK - 1);

    bfly_state_e state, state_nxt;
    logic [CNT_W-1:0] cnt;

    // Delay line: index 0 takes the new entry, index BLK-1 is the head.
    logic [DEPTH-1:0][WIDTH-1:0] dly_r [BLK];
    logic [DEPTH-1:0][WIDTH-1:0] dly_q [BLK];

    logic [DEPTH-1:0][WIDTH-1:0] ext_r, ext_q, sum_r, sum_q, diff_r, diff_q;
    logic [DEPTH-1:0][WIDTH-1:0] push_r, push_q;

    logic                        o_valid;
    logic [DEPTH-1:0][WIDTH-1:0] o_r, o_q;
    logic [SEL_W-1:0]            o_sel;

    bfly_add_sub #(.DIN_WIDTH(DIN_WIDTH), .WIDTH(WIDTH), .DEPTH(DEPTH)) u_as_r (
        .a     (dly_r[BLK-1]),
        .b     (din_R),
        .b_ext (ext_r),
        .sum   (sum_r),
        .diff  (diff_r)
    );

    bfly_add_sub #(.DIN_WIDTH(DIN_WIDTH), .WIDTH(WIDTH), .DEPTH(DEPTH)) u_as_q (
        .a     (dly_q[BLK-1]),
        .b     (din_Q),
        .b_ext (ext_q),
        .sum   (sum_q),
        .diff  (diff_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            cnt   <= '0;
        end else if (din_valid) begin
            state <= state_nxt;
            cnt   <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        push_r    = ext_r;
        push_q    = ext_q;
        if (state == BFLY) begin
            push_r = diff_r;
            push_q = diff_q;
        end
        if (cnt == CNT_LAST) begin
            case (state)
                FILL:    state_nxt = BFLY;
                BFLY:    state_nxt = EMIT;
                EMIT:    state_nxt = BFLY;
                default: state_nxt = FILL;
            endcase
        end
    end

    // Buffer contents are never observed before being refilled, so no reset.
    always_ff @(posedge clk) begin
        if (din_valid) begin
            dly_r[0] <= push_r;
            dly_q[0] <= push_q;
            for (int k = 1; k < BLK; k++) begin
                dly_r[k] <= dly_r[k-1];
                dly_q[k] <= dly_q[k-1];
            end
        end
    end

    // Data and select only change on accepted BFLY/EMIT beats; valid drops on
    // every other cycle so stalls leave the last result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_r     <= '0;
            o_q     <= '0;
            o_sel   <= '0;
        end else begin
            o_valid <= 1'b0;
            if (din_valid) begin
                case (state)
                    BFLY: begin
                        o_valid <= 1'b1;
                        o_r     <= sum_r;
                        o_q     <= sum_q;
                        o_sel   <= '0;
                    end
                    EMIT: begin
                        o_valid <= 1'b1;
                        o_r     <= dly_r[BLK-1];
                        o_q     <= dly_q[BLK-1];
                        o_sel   <= cnt[CNT_W-1 -: SEL_W];
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef BFLY_DOUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
            dout_R     <= '0;
            dout_Q     <= '0;
            select     <= '0;
        end else begin
            dout_valid <= o_valid;
            dout_R     <= o_r;
            dout_Q     <= o_q;
            select     <= o_sel;
        end
    end
`else
    assign dout_valid = o_valid;
    assign dout_R     = o_r;
    assign dout_Q     = o_q;
    assign select     = o_sel;
`endif

endmodule

// File: tb/tb_bfly_sdf_16.sv
// tb/tb_bfly_sdf_16.sv - directed table-driven bench for bfly_sdf_16
module tb_bfly_sdf_16;

    localparam int DW  = 10;
    localparam int W   = 11;
    localparam int DEP = 16;
`ifdef BFLY_DOUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                     clk;
    logic                     rst_n;
    logic                     din_valid;
    logic [DEP-1:0][DW-1:0]   din_R, din_Q;
    logic                     dout_valid;
    logic [DEP-1:0][W-1:0]    dout_R, dout_Q;
    logic [2:0]               select;

    bfly_sdf_16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din_R      (din_R),
        .din_Q      (din_Q),
        .dout_valid (dout_valid),
        .dout_R     (dout_R),
        .dout_Q     (dout_Q),
        .select     (select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane i input = k*i + c; expected lane i output = k*i + c.
    typedef struct {
        logic dv;
        int   irk, irc, iqk, iqc;
        logic hold;
        logic ev;
        int   erk, erc, eqk, eqc;
        logic [2:0] esel;
    } vec_t;

    typedef struct {
        logic                  v;
        logic [DEP-1:0][W-1:0] r;
        logic [DEP-1:0][W-1:0] q;
        logic [2:0]            sel;
        string                 nm;
    } exp_t;

    vec_t tbl [112];
    exp_t exp_q [$];
    exp_t last_exp;
    int   nvec = 0;
    int   nerr = 0;

    function automatic vec_t mk(input logic dv, input int irk, input int irc, input int iqk,
                                input int iqc, input logic hold, input logic ev, input int erk,
                                input int erc, input int eqk, input int eqc, input int sel);
        vec_t v;
        v.dv = dv; v.irk = irk; v.irc = irc; v.iqk = iqk; v.iqc = iqc;
        v.hold = hold; v.ev = ev; v.erk = erk; v.erc = erc; v.eqk = eqk; v.eqc = eqc;
        v.esel = 3'(sel);
        return v;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.v = 1'b0; e.r = '0; e.q = '0; e.sel = '0; e.nm = "";
        return e;
    endfunction

    task automatic check(input exp_t e);
        nvec++;
        if (dout_valid !== e.v || dout_R !== e.r || dout_Q !== e.q || select !== e.sel) begin
            nerr++;
            $display("FAIL %s: got v=%0b sel=%0d R=%h Q=%h, want v=%0b sel=%0d R=%h Q=%h",
                     e.nm, dout_valid, select, dout_R, dout_Q, e.v, e.sel, e.r, e.q);
        end
    endtask

    task automatic run_cycle(input vec_t v, input string nm);
        exp_t e;
        din_valid = v.dv;
        for (int i = 0; i < DEP; i++) begin
            din_R[i] = DW'(v.irk * i + v.irc);
            din_Q[i] = DW'(v.iqk * i + v.iqc);
        end
        if (!v.dv || v.hold) begin
            e   = last_exp;
            e.v = 1'b0;
        end else begin
            e.v   = v.ev;
            e.sel = v.esel;
            for (int i = 0; i < DEP; i++) begin
                e.r[i] = W'(v.erk * i + v.erc);
                e.q[i] = W'(v.eqk * i + v.eqc);
            end
            last_exp = e;
        end
        e.nm = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() >= LAT) check(exp_q.pop_front());
    endtask

    task automatic stall(input string nm);
        vec_t v;
        v = mk(1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 0, 0, 0, 0, 0);
        run_cycle(v, nm);
    endtask

    task automatic drain();
        for (int d = 1; d < LAT; d++) stall("drain");
    endtask

    task automatic do_reset(input string nm);
        exp_t z;
        rst_n = 1'b0;
        #1;
        z    = zero_exp();
        z.nm = nm;
        check(z);
        exp_q.delete();
        last_exp = zero_exp();
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        din_valid = 1'b0;
        din_R     = '0;
        din_Q     = '0;
        last_exp  = zero_exp();

        for (int k = 0; k < 16; k++) begin
            tbl[k]      = mk(1, 1, 0, 1, 0,       1, 0, 0, 0, 0, 0, 0);
            tbl[16 + k] = mk(1, 2, 0, -1, 0,      0, 1, 3, 0, 0, 0, 0);
            tbl[32 + k] = mk(1, 0, -512, 0, -512, 0, 1, -1, 0, 2, 0, k / 2);
            tbl[48 + k] = mk(1, 0, -512, 0, -512, 0, 1, 0, -1024, 0, -1024, 0);
            tbl[64 + k] = mk(1, 0, 511, 0, 511,   0, 1, 0, 0, 0, 0, k / 2);
            tbl[80 + k] = mk(1, 0, -512, 0, -512, 0, 1, 0, -1, 0, -1, 0);
            tbl[96 + k] = mk(1, 0, 0, 0, 0,      0, 1, 0, 1023, 0, 1023, k / 2);
        end

        do_reset("reset_init");

        for (int k = 0; k < 112; k++) run_cycle(tbl[k], $sformatf("main[%0d]", k));
        drain();

        do_reset("reset_stall");
        for (int k = 0; k < 48; k++) begin
            run_cycle(tbl[k], $sformatf("stall_beat[%0d]", k));
            stall($sformatf("stall_gap[%0d]", k));
        end
        drain();

        do_reset("reset_pre_mid");
        for (int k = 0; k < 23; k++) run_cycle(tbl[k], $sformatf("pre_mid[%0d]", k));
        do_reset("reset_mid_bfly");
        for (int k = 0; k < 32; k++) run_cycle(tbl[k], $sformatf("post_mid[%0d]", k));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
